// File: rtl/clock_time_keeper.sv
// clock_time_keeper: BCD 24-hour time-of-day register.
// Advances on the 1 Hz strobe in RUN mode, and steps hours and/or minutes on
// the time-set strobe while a set button is held (SET mode, seconds held at 00).
// Outputs are packed BCD digits for the display driver, registered, latency 1.
module clock_time_keeper (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_en,
  input  logic       i_1hz_stb,
  input  logic       i_timeset_stb,
  input  logic       i_set_hours,
  input  logic       i_set_minutes,
  output logic [5:0] o_hours,
  output logic [6:0] o_minutes,
  output logic [6:0] o_seconds,
  output logic       o_update_stb
);

  // Time digits, each kept as a separate BCD digit register
  logic [1:0] r_hours_tens;
  logic [3:0] r_hours_ones;
  logic [2:0] r_min_tens;
  logic [3:0] r_min_ones;
  logic [2:0] r_sec_tens;
  logic [3:0] r_sec_ones;
  logic       r_update_stb;

  logic [1:0] w_hours_tens_next;
  logic [3:0] w_hours_ones_next;
  logic [2:0] w_min_tens_next;
  logic [3:0] w_min_ones_next;
  logic [2:0] w_sec_tens_next;
  logic [3:0] w_sec_ones_next;
  logic       w_update_next;

  // Incremented field values, computed unconditionally and selected below
  logic [1:0] w_hours_tens_inc;
  logic [3:0] w_hours_ones_inc;
  logic [2:0] w_min_tens_inc;
  logic [3:0] w_min_ones_inc;
  logic [2:0] w_sec_tens_inc;
  logic [3:0] w_sec_ones_inc;

  logic w_set_mode;
  logic w_run_step;
  logic w_set_step;
  logic w_sec_wrap;
  logic w_min_wrap;
  logic w_hours_wrap;

  // Mode is decided by the button levels in the same cycle as the strobe, so a
  // strobe coincident with a press is handled in the new mode and only one
  // strobe type can ever act in a given cycle.
  assign w_set_mode = i_set_hours | i_set_minutes;
  assign w_run_step = i_en & ~w_set_mode & i_1hz_stb;
  assign w_set_step = i_en &  w_set_mode & i_timeset_stb;

  assign w_sec_wrap   = (r_sec_tens == 3'd5) && (r_sec_ones == 4'd9);
  assign w_min_wrap   = (r_min_tens == 3'd5) && (r_min_ones == 4'd9);
  assign w_hours_wrap = (r_hours_tens == 2'd2) && (r_hours_ones == 4'd3);

  // Per-field +1 with BCD ones->tens carry and field wrap (59->00, 23->00)
  always_comb begin
    w_sec_tens_inc   = r_sec_tens;
    w_sec_ones_inc   = r_sec_ones + 4'd1;
    w_min_tens_inc   = r_min_tens;
    w_min_ones_inc   = r_min_ones + 4'd1;
    w_hours_tens_inc = r_hours_tens;
    w_hours_ones_inc = r_hours_ones + 4'd1;

    if (r_sec_ones == 4'd9) begin
      w_sec_ones_inc = 4'd0;
      w_sec_tens_inc = w_sec_wrap ? 3'd0 : r_sec_tens + 3'd1;
    end

    if (r_min_ones == 4'd9) begin
      w_min_ones_inc = 4'd0;
      w_min_tens_inc = w_min_wrap ? 3'd0 : r_min_tens + 3'd1;
    end

    // 23 is checked first because its ones digit is not 9
    if (w_hours_wrap) begin
      w_hours_ones_inc = 4'd0;
      w_hours_tens_inc = 2'd0;
    end else if (r_hours_ones == 4'd9) begin
      w_hours_ones_inc = 4'd0;
      w_hours_tens_inc = r_hours_tens + 2'd1;
    end
  end

  // Next-state selection: RUN ripple-carry count, or SET step of chosen fields
  always_comb begin
    w_hours_tens_next = r_hours_tens;
    w_hours_ones_next = r_hours_ones;
    w_min_tens_next   = r_min_tens;
    w_min_ones_next   = r_min_ones;
    w_sec_tens_next   = r_sec_tens;
    w_sec_ones_next   = r_sec_ones;
    w_update_next     = 1'b0;

    if (w_run_step) begin
      w_update_next   = 1'b1;
      w_sec_tens_next = w_sec_tens_inc;
      w_sec_ones_next = w_sec_ones_inc;
      if (w_sec_wrap) begin
        w_min_tens_next = w_min_tens_inc;
        w_min_ones_next = w_min_ones_inc;
        if (w_min_wrap) begin
          w_hours_tens_next = w_hours_tens_inc;
          w_hours_ones_next = w_hours_ones_inc;
        end
      end
    end else if (w_set_step) begin
      // Every set step pulses the update strobe, even if seconds were already 00
      w_update_next   = 1'b1;
      w_sec_tens_next = 3'd0;
      w_sec_ones_next = 4'd0;
      if (i_set_minutes) begin
        w_min_tens_next = w_min_tens_inc;
        w_min_ones_next = w_min_ones_inc;
      end
      if (i_set_hours) begin
        w_hours_tens_next = w_hours_tens_inc;
        w_hours_ones_next = w_hours_ones_inc;
      end
    end
  end

  // Time and update-strobe registers, cleared immediately by reset
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_hours_tens <= 2'd0;
      r_hours_ones <= 4'd0;
      r_min_tens   <= 3'd0;
      r_min_ones   <= 4'd0;
      r_sec_tens   <= 3'd0;
      r_sec_ones   <= 4'd0;
      r_update_stb <= 1'b0;
    end else begin
      r_hours_tens <= w_hours_tens_next;
      r_hours_ones <= w_hours_ones_next;
      r_min_tens   <= w_min_tens_next;
      r_min_ones   <= w_min_ones_next;
      r_sec_tens   <= w_sec_tens_next;
      r_sec_ones   <= w_sec_ones_next;
      r_update_stb <= w_update_next;
    end
  end

  assign o_hours      = {r_hours_tens, r_hours_ones};
  assign o_minutes    = {r_min_tens, r_min_ones};
  assign o_seconds    = {r_sec_tens, r_sec_ones};
  assign o_update_stb = r_update_stb;

endmodule

// File: tb/tb_clock_time_keeper.sv
// tb_clock_time_keeper: directed plus randomized checks of clock_time_keeper
// against a model that keeps time as plain integers (hours, minutes, seconds).
module tb_clock_time_keeper;

  logic       i_clk;
  logic       i_reset;
  logic       i_en;
  logic       i_1hz_stb;
  logic       i_timeset_stb;
  logic       i_set_hours;
  logic       i_set_minutes;
  logic [5:0] o_hours;
  logic [6:0] o_minutes;
  logic [6:0] o_seconds;
  logic       o_update_stb;

  int checks = 0;
  int errors = 0;
  int m_h = 0;
  int m_m = 0;
  int m_s = 0;
  logic m_upd = 1'b0;
  int upd_count = 0;

  clock_time_keeper dut (
    .i_clk         (i_clk),
    .i_reset       (i_reset),
    .i_en          (i_en),
    .i_1hz_stb     (i_1hz_stb),
    .i_timeset_stb (i_timeset_stb),
    .i_set_hours   (i_set_hours),
    .i_set_minutes (i_set_minutes),
    .o_hours       (o_hours),
    .o_minutes     (o_minutes),
    .o_seconds     (o_seconds),
    .o_update_stb  (o_update_stb)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  function automatic logic [31:0] bcd(input int v);
    return 32'(((v / 10) << 4) | (v % 10));
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".hours"},   32'(o_hours),      bcd(m_h));
    chk({tag, ".minutes"}, 32'(o_minutes),    bcd(m_m));
    chk({tag, ".seconds"}, 32'(o_seconds),    bcd(m_s));
    chk({tag, ".update"},  32'(o_update_stb), 32'(m_upd));
  endtask

  // Reference behaviour for one clock edge, expressed on integer time
  task automatic model(input logic en, hz, ts, sh, sm);
    int total;
    m_upd = 1'b0;
    if (en) begin
      if (sh | sm) begin
        if (ts) begin
          if (sm) m_m = (m_m + 1) % 60;
          if (sh) m_h = (m_h + 1) % 24;
          m_s = 0;
          m_upd = 1'b1;
        end
      end else if (hz) begin
        total = ((m_h * 60 + m_m) * 60 + m_s + 1) % 86400;
        m_h = total / 3600;
        m_m = (total / 60) % 60;
        m_s = total % 60;
        m_upd = 1'b1;
      end
    end
  endtask

  // One clock transaction: drive, clock, compare against the model
  task automatic step(input string tag, input logic en, hz, ts, sh, sm);
    i_en = en; i_1hz_stb = hz; i_timeset_stb = ts;
    i_set_hours = sh; i_set_minutes = sm;
    @(posedge i_clk);
    #1;
    model(en, hz, ts, sh, sm);
    if (o_update_stb) upd_count++;
    chk_all(tag);
    $display("[%0t] %s en=%0b hz=%0b ts=%0b sh=%0b sm=%0b -> %02h:%02h:%02h upd=%0b",
             $time, tag, en, hz, ts, sh, sm, o_hours, o_minutes, o_seconds, o_update_stb);
  endtask

  // Asynchronous reset asserted between edges, checked before the next edge
  task automatic do_reset(input string tag);
    #2;
    i_reset = 1'b1;
    #1;
    m_h = 0; m_m = 0; m_s = 0; m_upd = 1'b0;
    chk_all({tag, ".async"});
    @(posedge i_clk);
    #1;
    chk_all({tag, ".held"});
    i_reset = 1'b0;
    upd_count = 0;
    $display("[%0t] %s reset applied", $time, tag);
  endtask

  initial begin
    i_reset = 1'b1;
    i_en = 1'b0; i_1hz_stb = 1'b0; i_timeset_stb = 1'b0;
    i_set_hours = 1'b0; i_set_minutes = 1'b0;
    #1;
    chk_all("reset_state");
    @(posedge i_clk);
    #1;
    i_reset = 1'b0;
    upd_count = 0;

    // 61 one-second strobes -> 00:01:01 with 61 update pulses
    for (int i = 0; i < 61; i++) step("run61", 1, 1, 0, 0, 0);
    chk("run61.min_const", 32'(o_minutes), 32'h01);
    chk("run61.sec_const", 32'(o_seconds), 32'h01);
    chk("run61.upd_count", 32'(upd_count), 32'd61);

    // Preload 23:59:59 and roll over to 00:00:00
    do_reset("rst1");
    for (int i = 0; i < 23; i++) step("set_h", 1, 0, 1, 1, 0);
    for (int i = 0; i < 59; i++) step("set_m", 1, 0, 1, 0, 1);
    for (int i = 0; i < 59; i++) step("run_s", 1, 1, 0, 0, 0);
    chk("pre_roll.hours", 32'(o_hours), 32'h23);
    upd_count = 0;
    step("rollover", 1, 1, 0, 0, 0);
    step("rollover_idle", 1, 0, 0, 0, 0);
    chk("roll.hours", 32'(o_hours), 32'h00);
    chk("roll.upd_count", 32'(upd_count), 32'd1);

    // 12:34:56, minutes set x26 with concurrent 1 Hz strobes -> 12:00:00
    do_reset("rst2");
    for (int i = 0; i < 12; i++) step("set_h", 1, 0, 1, 1, 0);
    for (int i = 0; i < 34; i++) step("set_m", 1, 0, 1, 0, 1);
    for (int i = 0; i < 56; i++) step("run_s", 1, 1, 0, 0, 0);
    for (int i = 0; i < 26; i++) step("set_m26", 1, 1, 1, 0, 1);
    chk("setm.hours", 32'(o_hours), 32'h12);
    chk("setm.minutes", 32'(o_minutes), 32'h00);
    chk("setm.seconds", 32'(o_seconds), 32'h00);
    // 1 Hz while in SET mode: clock paused
    step("set_pause", 1, 1, 0, 0, 1);

    // Both buttons from 09:58:07, 3 set strobes -> 12:01:00
    do_reset("rst3");
    for (int i = 0; i < 9; i++) step("set_h", 1, 0, 1, 1, 0);
    for (int i = 0; i < 58; i++) step("set_m", 1, 0, 1, 0, 1);
    for (int i = 0; i < 7; i++) step("run_s", 1, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) step("set_both", 1, 0, 1, 1, 1);
    chk("both.hours", 32'(o_hours), 32'h12);
    chk("both.minutes", 32'(o_minutes), 32'h01);
    chk("both.seconds", 32'(o_seconds), 32'h00);
    // Set step with seconds already 00 still pulses update
    step("set_zero_sec", 1, 0, 1, 0, 1);

    // Enable low: 5 strobes of each type in both modes, nothing changes
    upd_count = 0;
    for (int i = 0; i < 5; i++) step("dis_hz", 0, 1, 0, 0, 0);
    for (int i = 0; i < 5; i++) step("dis_ts", 0, 0, 1, 1, 1);
    for (int i = 0; i < 5; i++) step("dis_mix", 0, 1, 1, 0, 1);
    chk("dis.upd_count", 32'(upd_count), 32'd0);
    chk("dis.minutes", 32'(o_minutes), 32'h02);

    // Back-to-back strobes then reset mid-count; resume from 00:00:00
    step("b2b", 1, 1, 0, 0, 0);
    step("b2b", 1, 1, 0, 0, 0);
    do_reset("rst4");
    step("resume", 1, 1, 0, 0, 0);
    chk("resume.seconds", 32'(o_seconds), 32'h01);

    // Reset asserted right in the 23:59:59 rollover cycle
    for (int i = 0; i < 23; i++) step("set_h", 1, 0, 1, 1, 0);
    for (int i = 0; i < 59; i++) step("set_m", 1, 0, 1, 0, 1);
    for (int i = 0; i < 59; i++) step("run_s", 1, 1, 0, 0, 0);
    i_1hz_stb = 1'b1;
    do_reset("rst_roll");
    step("resume2", 1, 1, 0, 0, 0);

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      step("rand",
           logic'($urandom_range(0, 9) < 8),
           logic'($urandom_range(0, 9) < 5),
           logic'($urandom_range(0, 9) < 4),
           logic'($urandom_range(0, 9) < 2),
           logic'($urandom_range(0, 9) < 2));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
